// File: rtl/clk_div_ctrl.sv
// Programmable clock divider / tick generator with start, stop and burst sequencing.
// Divisor updates are deferred to a period boundary so clkOut never glitches.
module clk_div_ctrl #(
    parameter int CNT_W       = 26,
    parameter int DEFAULT_DIV = 25000000,
    parameter int BURST_W     = 8
) (
    input  logic               clkIn,
    input  logic               rst,
    input  logic               cfg_valid,
    input  logic [CNT_W-1:0]   cfg_div,
    output logic               cfg_ready,
    input  logic               start,
    input  logic               stop,
    input  logic [BURST_W-1:0] burst_len,
    output logic               tick,
    output logic               clkOut,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   cur_div
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   div_reg;
    logic [CNT_W-1:0]   pend_div;
    logic               pend_valid;
    logic [BURST_W-1:0] remaining;
    logic               continuous;
    logic               clk_q;
    logic               accept;

    assign cfg_ready = (state == IDLE) || !pend_valid;
    assign accept    = cfg_valid && cfg_ready;
    assign busy      = (state == RUN);
    assign cur_div   = div_reg;
    assign clkOut    = clk_q;

    always_ff @(posedge clkIn or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            div_reg    <= CNT_W'(DEFAULT_DIV);
            pend_div   <= '0;
            pend_valid <= 1'b0;
            remaining  <= '0;
            continuous <= 1'b0;
            clk_q      <= 1'b0;
            tick       <= 1'b0;
            done       <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    if (accept) begin
                        div_reg <= cfg_div;
                    end
                    if (start && !stop) begin
                        state      <= RUN;
                        remaining  <= burst_len;
                        continuous <= (burst_len == '0);
                    end
                end
                RUN: begin
                    // Stop outranks a coincident terminal count; any pending divisor is committed on the way out.
                    if (stop) begin
                        state      <= IDLE;
                        count      <= '0;
                        clk_q      <= 1'b0;
                        pend_valid <= 1'b0;
                        if (accept) begin
                            div_reg <= cfg_div;
                        end else if (pend_valid) begin
                            div_reg <= pend_div;
                        end
                    end else if (count == div_reg) begin
                        count <= '0;
                        tick  <= 1'b1;
                        clk_q <= ~clk_q;
                        if (accept) begin
                            div_reg <= cfg_div;
                        end else if (pend_valid) begin
                            div_reg    <= pend_div;
                            pend_valid <= 1'b0;
                        end
                        if (!continuous) begin
                            remaining <= remaining - BURST_W'(1);
                            if (remaining == BURST_W'(1)) begin
                                state <= IDLE;
                                done  <= 1'b1;
                            end
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                        if (accept) begin
                            pend_div   <= cfg_div;
                            pend_valid <= 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl: reset, continuous run, burst, mid-run reconfiguration,
// stop collisions and asynchronous reset mid-burst, all with hand-computed expectations.
module tb_clk_div_ctrl;

    localparam int CNT_W   = 26;
    localparam int BURST_W = 8;
    localparam logic [CNT_W-1:0] DEF_DIV = 26'd25000000;

    logic               clkIn;
    logic               rst;
    logic               cfg_valid;
    logic [CNT_W-1:0]   cfg_div;
    logic               cfg_ready;
    logic               start;
    logic               stop;
    logic [BURST_W-1:0] burst_len;
    logic               tick;
    logic               clkOut;
    logic               busy;
    logic               done;
    logic [CNT_W-1:0]   cur_div;

    int checks = 0;
    int errors = 0;

    clk_div_ctrl #(.CNT_W(CNT_W), .DEFAULT_DIV(25000000), .BURST_W(BURST_W)) dut (
        .clkIn(clkIn), .rst(rst),
        .cfg_valid(cfg_valid), .cfg_div(cfg_div), .cfg_ready(cfg_ready),
        .start(start), .stop(stop), .burst_len(burst_len),
        .tick(tick), .clkOut(clkOut), .busy(busy), .done(done), .cur_div(cur_div)
    );

    initial clkIn = 1'b0;
    always #5 clkIn = ~clkIn;

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic checkWord(input string tag, input logic [CNT_W-1:0] obs, input logic [CNT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOut(input string tag, input logic t, input logic c, input logic b, input logic d);
        checkBit({tag, ".tick"}, tick, t);
        checkBit({tag, ".clkOut"}, clkOut, c);
        checkBit({tag, ".busy"}, busy, b);
        checkBit({tag, ".done"}, done, d);
    endtask

    // Advance n clock edges, landing 1 time unit after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clkIn);
            #1;
        end
    endtask

    initial begin
        rst = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        start = 1'b0; stop = 1'b0; burst_len = '0;

        // Reset pulse, then idle for 100 cycles.
        #2 rst = 1'b1;
        #1;
        checkOut("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("rst.cfg_ready", cfg_ready, 1'b1);
        checkWord("rst.cur_div", cur_div, DEF_DIV);
        #9 rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cyc(1);
            checkOut($sformatf("idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            checkBit($sformatf("idle%0d.cfg_ready", i), cfg_ready, 1'b1);
            checkWord($sformatf("idle%0d.cur_div", i), cur_div, DEF_DIV);
        end

        // Program divisor 3 and run continuously.
        cfg_valid = 1'b1; cfg_div = 26'd3;
        cyc(1);
        cfg_valid = 1'b0;
        checkWord("cont.cur_div", cur_div, 26'd3);
        start = 1'b1; burst_len = 8'd0;
        cyc(1);
        start = 1'b0;
        checkOut("cont.k0", 1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            checkOut($sformatf("cont.k%0d", k), (k % 4 == 0), ((k / 4) % 2 == 1), 1'b1, 1'b0);
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        checkOut("cont.stop", 1'b0, 1'b0, 1'b0, 1'b0);

        // Burst of 3 ticks at divisor 1.
        cfg_valid = 1'b1; cfg_div = 26'd1;
        cyc(1);
        cfg_valid = 1'b0;
        checkWord("burst.cur_div", cur_div, 26'd1);
        start = 1'b1; burst_len = 8'd3;
        cyc(1);
        start = 1'b0; burst_len = 8'd0;
        for (int k = 1; k <= 5; k++) begin
            cyc(1);
            checkBit($sformatf("burst.k%0d.tick", k), tick, (k % 2 == 0));
            checkBit($sformatf("burst.k%0d.busy", k), busy, 1'b1);
            checkBit($sformatf("burst.k%0d.done", k), done, 1'b0);
        end
        cyc(1);
        checkBit("burst.k6.tick", tick, 1'b1);
        checkBit("burst.k6.done", done, 1'b1);
        checkBit("burst.k6.clkOut", clkOut, 1'b1);
        for (int k = 7; k <= 10; k++) begin
            cyc(1);
            checkOut($sformatf("burst.k%0d", k), 1'b0, 1'b1, 1'b0, 1'b0);
        end

        // Mid-run reconfiguration: 5 -> 2 pending, then a second write of 4 waits for ready.
        cfg_valid = 1'b1; cfg_div = 26'd5;
        cyc(1);
        cfg_valid = 1'b0;
        checkWord("recfg.cur_div5", cur_div, 26'd5);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(1);
        checkBit("recfg.ready_k1", cfg_ready, 1'b1);
        cfg_valid = 1'b1; cfg_div = 26'd2;
        cyc(1);
        cfg_div = 26'd4;
        checkBit("recfg.ready_k2", cfg_ready, 1'b0);
        checkWord("recfg.div_k2", cur_div, 26'd5);
        for (int k = 3; k <= 5; k++) begin
            cyc(1);
            checkBit($sformatf("recfg.k%0d.tick", k), tick, 1'b0);
            checkBit($sformatf("recfg.k%0d.ready", k), cfg_ready, 1'b0);
            checkWord($sformatf("recfg.k%0d.div", k), cur_div, 26'd5);
        end
        cyc(1);
        checkBit("recfg.k6.tick", tick, 1'b1);
        checkWord("recfg.k6.div", cur_div, 26'd2);
        checkBit("recfg.k6.ready", cfg_ready, 1'b1);
        cyc(1);
        cfg_valid = 1'b0;
        checkBit("recfg.k7.tick", tick, 1'b0);
        checkBit("recfg.k7.ready", cfg_ready, 1'b0);
        checkWord("recfg.k7.div", cur_div, 26'd2);
        cyc(1);
        checkBit("recfg.k8.tick", tick, 1'b0);
        cyc(1);
        checkBit("recfg.k9.tick", tick, 1'b1);
        checkWord("recfg.k9.div", cur_div, 26'd4);
        checkBit("recfg.k9.ready", cfg_ready, 1'b1);
        for (int k = 10; k <= 14; k++) begin
            cyc(1);
            checkBit($sformatf("recfg.k%0d.tick", k), tick, (k == 14));
        end

        // Stop coinciding with a terminal count: no tick, clkOut forced low.
        for (int k = 15; k <= 23; k++) begin
            cyc(1);
            checkBit($sformatf("stopc.k%0d.tick", k), tick, (k == 19));
        end
        checkBit("stopc.k23.clkOut", clkOut, 1'b1);
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        checkOut("stopc.k24", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(6);
        checkOut("stopc.after", 1'b0, 1'b0, 1'b0, 1'b0);

        // start and stop together in IDLE stays idle.
        start = 1'b1; stop = 1'b1;
        cyc(1);
        start = 1'b0; stop = 1'b0;
        checkOut("both.k1", 1'b0, 1'b0, 1'b0, 1'b0);
        cyc(6);
        checkOut("both.k7", 1'b0, 1'b0, 1'b0, 1'b0);

        // Async reset mid-burst with a pending divisor.
        cfg_valid = 1'b1; cfg_div = 26'd2;
        cyc(1);
        cfg_valid = 1'b0;
        start = 1'b1; burst_len = 8'd5;
        cyc(1);
        start = 1'b0; burst_len = 8'd0;
        for (int k = 1; k <= 6; k++) begin
            cyc(1);
            checkBit($sformatf("arst.k%0d.tick", k), tick, (k % 3 == 0));
        end
        cfg_valid = 1'b1; cfg_div = 26'd7;
        cyc(1);
        cfg_valid = 1'b0;
        checkBit("arst.pending", cfg_ready, 1'b0);
        #2 rst = 1'b1;
        #1;
        checkOut("arst.now", 1'b0, 1'b0, 1'b0, 1'b0);
        checkBit("arst.now.ready", cfg_ready, 1'b1);
        checkWord("arst.now.div", cur_div, DEF_DIV);
        #3 rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            checkOut($sformatf("arst.idle%0d", i), 1'b0, 1'b0, 1'b0, 1'b0);
            checkWord($sformatf("arst.idle%0d.div", i), cur_div, DEF_DIV);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
